// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_arbiter
// Description : Round-robin arbiter granting NUM_REQ cores one at a time
//               access to a single-ported shared memory. Each accepted
//               request is checked for word alignment and range. A legal
//               access is issued to the memory, and a rejected one is
//               answered with err. The grant pointer advances only when a
//               transaction completes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_i        in   [NUM_REQ]            per-core request, held until done
//   we_i         in   [NUM_REQ]            per-core write enable (1 = write)
//   addr_i       in   [NUM_REQ*ADDR_WIDTH] per-core byte address, core 0 at LSBs
//   wdata_i      in   [NUM_REQ*DATA_WIDTH] per-core write data, core 0 at LSBs
//   gnt_o        out  [NUM_REQ]            one-hot accept pulse
//   done_o       out  [NUM_REQ]            one-hot completion pulse
//   err_o        out  access rejected, valid with done
//   rdata_o      out  [DATA_WIDTH]         read data, valid with done
//   mem_en_o     out  memory enable
//   mem_we_o     out  memory write strobe
//   mem_addr_o   out  [clog2(MEM_SIZE)]    memory word index
//   mem_wdata_o  out  [DATA_WIDTH]         memory write data
//   mem_rdata_i  in   [DATA_WIDTH]         memory read data, MEM_LATENCY cycles after mem_en
//   busy_o       out  high whenever a transaction is in flight
// ============================================================================
module shared_mem_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int MEM_SIZE    = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic                          err_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [$clog2(MEM_SIZE)-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                          busy_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int MEM_AW = $clog2(MEM_SIZE);
    localparam int CNT_W  = 3;

    localparam logic [CNT_W-1:0]      LAT_M1    = CNT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]        NUM_REQ_X = (IDX_W+1)'(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS = ADDR_WIDTH'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        win_q;
    logic                    we_q;
    logic                    legal_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic [NUM_REQ-1:0]      done_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic [MEM_AW-1:0]       mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    // Arbitration: first requester found when scanning upward from rr_ptr.
    logic                    arb_found;
    logic [IDX_W-1:0]        arb_idx;

    always_comb begin
        logic [IDX_W:0] idx;
        idx       = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (idx >= NUM_REQ_X) begin
                idx = idx - NUM_REQ_X;
            end
            if (!arb_found && req_i[idx[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = idx[IDX_W-1:0];
            end
        end
    end

    // Request fields of the selected core.
    logic                    arb_we;
    logic [ADDR_WIDTH-1:0]   arb_addr;
    logic [DATA_WIDTH-1:0]   arb_wdata;
    logic                    arb_legal;

    always_comb begin
        arb_we    = 1'b0;
        arb_addr  = '0;
        arb_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                arb_we    = we_i[i];
                arb_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                arb_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Legal means 8-byte aligned and the word index falls inside the memory.
    assign arb_legal = (arb_addr[2:0] == 3'b000) &&
                       ({3'b000, arb_addr[ADDR_WIDTH-1:3]} < MEM_WORDS);

    // The ISSUE-cycle outputs (gnt, mem_*) are loaded on the IDLE->ISSUE edge
    // so they are registered and appear exactly in the ISSUE cycle. Likewise
    // done/err/rdata are loaded on the edge into RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            we_q        <= 1'b0;
            legal_q     <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_found) begin
                        win_q       <= arb_idx;
                        we_q        <= arb_we;
                        legal_q     <= arb_legal;
                        gnt_q       <= NUM_REQ'(1) << arb_idx;
                        mem_en_q    <= arb_legal;
                        mem_we_q    <= arb_legal & arb_we;
                        mem_addr_q  <= arb_addr[MEM_AW+2:3];
                        mem_wdata_q <= arb_wdata;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    gnt_q    <= '0;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (legal_q) begin
                        cnt_q   <= LAT_M1;
                        state_q <= S_WAIT;
                    end else begin
                        // Rejected access skips the memory entirely.
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        done_q  <= NUM_REQ'(1) << win_q;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : mem_rdata_i;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    done_q   <= '0;
                    err_q    <= 1'b0;
                    rdata_q  <= '0;
                    rr_ptr_q <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire
